// File: rtl/led_pattern_ctrl_if.sv
// Pattern-controller bus: the switch and button inputs plus the registered LED outputs.
interface led_pattern_ctrl_if #(
  parameter int N_LEDS = 4
);
  logic [2:0]        i_sw;
  logic              i_mode_btn;
  logic [N_LEDS-1:0] o_led;
  logic [1:0]        o_mode;
  logic              o_tick;

  modport master (
    output i_sw, i_mode_btn,
    input  o_led, o_mode, o_tick
  );

  modport slave (
    input  i_sw, i_mode_btn,
    output o_led, o_mode, o_tick
  );
endinterface

// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer: a prescaler tick generator and a four-mode pattern FSM.
//
// state    | meaning
// ---------+--------------------------------------------------
// SHIFT_L  | single lit LED rotating towards the MSB
// SHIFT_R  | single lit LED rotating towards the LSB
// FLASH    | all LEDs toggling between on and off
// PINGPONG | single lit LED bouncing between the end LEDs
module led_pattern_ctrl #(
  parameter int              N_LEDS = 4,
  parameter int              N_CNT  = 32,
  parameter logic [N_CNT-1:0] LIM0  = 32'd49999999,
  parameter logic [N_CNT-1:0] LIM1  = 32'd24999999,
  parameter logic [N_CNT-1:0] LIM2  = 32'd12499999,
  parameter logic [N_CNT-1:0] LIM3  = 32'd6249999
) (
  input  logic               clk,
  input  logic               i_reset,
  led_pattern_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    SHIFT_L  = 2'b00,
    SHIFT_R  = 2'b01,
    FLASH    = 2'b10,
    PINGPONG = 2'b11
  } mode_t;

  localparam logic [N_LEDS-1:0] LED_LSB = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] LED_MSB = LED_LSB << (N_LEDS - 1);

  mode_t             r_mode;
  mode_t             w_mode_nxt;
  logic [N_CNT-1:0]  r_cnt;
  logic [N_LEDS-1:0] r_led;
  logic              r_dir;        // 0 = moving left (towards MSB), 1 = moving right
  logic              r_tick;
  logic              r_btn_prev;

  logic              w_btn_rise;
  logic              w_en;
  logic [N_CNT-1:0]  w_limit;
  logic              w_tc;
  logic [N_LEDS-1:0] w_load_led;
  logic              w_load_dir;
  logic [N_LEDS-1:0] w_step_led;
  logic              w_step_dir;

  assign w_btn_rise = bus.i_mode_btn & ~r_btn_prev;
  assign w_en       = bus.i_sw[0];

  // Speed select; >= compare lets a shrinking limit fire on the next edge.
  always_comb begin
    w_limit = LIM0;
    case (bus.i_sw[2:1])
      2'b00:   w_limit = LIM0;
      2'b01:   w_limit = LIM1;
      2'b10:   w_limit = LIM2;
      default: w_limit = LIM3;
    endcase
  end

  assign w_tc = (r_cnt >= w_limit);

  // Mode state register; button history resets high so a held button is ignored.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_mode     <= SHIFT_L;
      r_btn_prev <= 1'b1;
    end else begin
      r_mode     <= w_mode_nxt;
      r_btn_prev <= bus.i_mode_btn;
    end
  end

  // Next mode: advance on a button rising edge regardless of enable.
  always_comb begin
    w_mode_nxt = r_mode;
    if (w_btn_rise) begin
      case (r_mode)
        SHIFT_L:  w_mode_nxt = SHIFT_R;
        SHIFT_R:  w_mode_nxt = FLASH;
        FLASH:    w_mode_nxt = PINGPONG;
        default:  w_mode_nxt = SHIFT_L;
      endcase
    end
  end

  // Mode-dependent pattern: reload value for the incoming mode and one step of the current one.
  always_comb begin
    w_load_led = LED_LSB;
    w_load_dir = 1'b0;
    case (w_mode_nxt)
      SHIFT_R: w_load_led = LED_MSB;
      FLASH:   w_load_led = '1;
      default: w_load_led = LED_LSB;
    endcase

    w_step_led = r_led;
    w_step_dir = r_dir;
    case (r_mode)
      SHIFT_L: w_step_led = {r_led[N_LEDS-2:0], r_led[N_LEDS-1]};
      SHIFT_R: w_step_led = {r_led[0], r_led[N_LEDS-1:1]};
      FLASH:   w_step_led = ~r_led;
      default: begin
        if (!r_dir && r_led[N_LEDS-1]) begin
          w_step_dir = 1'b1;
          w_step_led = r_led >> 1;
        end else if (r_dir && r_led[0]) begin
          w_step_dir = 1'b0;
          w_step_led = r_led << 1;
        end else if (r_dir) begin
          w_step_led = r_led >> 1;
        end else begin
          w_step_led = r_led << 1;
        end
      end
    endcase
  end

  // Prescaler and pattern register; a mode change outranks a terminal count.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_led  <= LED_LSB;
      r_dir  <= 1'b0;
    end else if (w_btn_rise) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_led  <= w_load_led;
      r_dir  <= w_load_dir;
    end else if (!w_en) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (w_tc) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
      r_led  <= w_step_led;
      r_dir  <= w_step_dir;
    end else begin
      r_cnt  <= r_cnt + N_CNT'(1);
      r_tick <= 1'b0;
    end
  end

  assign bus.o_led  = r_led;
  assign bus.o_mode = r_mode;
  assign bus.o_tick = r_tick;

endmodule
